// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg
//   Shared definitions for the SRAM arbiter: FSM state encoding, the command
//   codes understood by sram_interface, and the split of the 19-bit request
//   address into the half-select bit and the 18-bit word address.
package sram_arb_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_t;

   localparam logic [1:0] CMD_IDLE  = 2'd0;
   localparam logic [1:0] CMD_READ  = 2'd1;
   localparam logic [1:0] CMD_WRITE = 2'd2;

   localparam int ADDR_W   = 19;
   localparam int DATA_W   = 16;
   localparam int CS_BIT   = 18;
   localparam int WORD_MSB = 17;

   function automatic logic [1:0] op_to_cmd(input logic wr);
      return wr ? CMD_WRITE : CMD_READ;
   endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// sram_arb_rr
//   Two-way request picker.
//   Ports:
//     valid0_i, valid1_i : request pending on port 0 / port 1
//     ptr_i              : port preferred when both request (round-robin pointer)
//     fixed_i            : 1 = port 0 always wins a tie, ptr_i ignored
//     any_o              : at least one request pending
//     grant_o            : index of the winning port (valid only when any_o)
module sram_arb_rr (
   input  logic valid0_i,
   input  logic valid1_i,
   input  logic ptr_i,
   input  logic fixed_i,
   output logic any_o,
   output logic grant_o
);

   always_comb begin
      any_o   = valid0_i | valid1_i;
      grant_o = 1'b0;
      if (valid0_i && valid1_i) begin
         grant_o = fixed_i ? 1'b0 : ptr_i;
      end else if (valid1_i) begin
         grant_o = 1'b1;
      end
   end

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares the single sram_interface port between the sensor logger (port 0)
//   and the telemetry readback path (port 1). One transaction at a time:
//   IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
//   Ports:
//     CLK_48MHZ, RESET            : clock, asynchronous active-high reset
//     REQn_VALID/WRITE/ADDR/WDATA : request from port n (held until REQn_READY)
//     REQn_READY                  : one-cycle accept pulse
//     REQn_DONE, REQn_RDATA       : completion pulse; read data held between reads
//     SRAM_CMD/ADDR/CS/WDATA      : command side of sram_interface
//     SRAM_STATUS, SRAM_RDATA     : busy flag and read data from sram_interface
//     ERR_TIMEOUT                 : sticky transaction-timeout flag
//   Build option: define SRAM_ARB_TIMEOUT_EN to abort a transaction that spends
//   TIMEOUT_CYCLES in ISSUE+WAIT; otherwise the FSM waits on SRAM_STATUS forever
//   and ERR_TIMEOUT is tied 0.
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int FIXED_PRIO     = 0,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              CLK_48MHZ,
   input  logic              RESET,
   input  logic              REQ0_VALID,
   input  logic              REQ0_WRITE,
   input  logic [ADDR_W-1:0] REQ0_ADDR,
   input  logic [DATA_W-1:0] REQ0_WDATA,
   output logic              REQ0_READY,
   output logic              REQ0_DONE,
   output logic [DATA_W-1:0] REQ0_RDATA,
   input  logic              REQ1_VALID,
   input  logic              REQ1_WRITE,
   input  logic [ADDR_W-1:0] REQ1_ADDR,
   input  logic [DATA_W-1:0] REQ1_WDATA,
   output logic              REQ1_READY,
   output logic              REQ1_DONE,
   output logic [DATA_W-1:0] REQ1_RDATA,
   output logic [1:0]        SRAM_CMD,
   output logic [WORD_MSB:0] SRAM_ADDR,
   output logic              SRAM_CS,
   output logic [DATA_W-1:0] SRAM_WDATA,
   input  logic              SRAM_STATUS,
   input  logic [DATA_W-1:0] SRAM_RDATA,
   output logic              ERR_TIMEOUT
);

   arb_state_t        state_q, state_d;
   logic              ptr_q, ptr_d;      // port preferred on the next tie
   logic              win_q, win_d;      // port owning the current transaction
   logic              wr_q, wr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata0_q, rdata0_d;
   logic [DATA_W-1:0] rdata1_q, rdata1_d;
   logic              any_valid, grant;
   logic              timeout_hit;

   sram_arb_rr u_rr (
      .valid0_i (REQ0_VALID),
      .valid1_i (REQ1_VALID),
      .ptr_i    (ptr_q),
      .fixed_i  (FIXED_PRIO != 0),
      .any_o    (any_valid),
      .grant_o  (grant)
   );

`ifdef SRAM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q;

   // Counts cycles spent in ISSUE+WAIT; cleared whenever the FSM is elsewhere.
   always_comb begin
      cnt_d = '0;
      if (state_q == ST_ISSUE || state_q == ST_WAIT) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   assign timeout_hit = (state_q == ST_ISSUE || state_q == ST_WAIT) &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge CLK_48MHZ or posedge RESET) begin
      if (RESET) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_q | timeout_hit;
      end
   end

   assign ERR_TIMEOUT = err_q;
`else
   // Timeout disabled; the parameter stays referenced so both builds share
   // one parameter list.
   assign timeout_hit = 1'b0 & (TIMEOUT_CYCLES > 0);
   assign ERR_TIMEOUT = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      win_d      = win_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata0_d   = rdata0_q;
      rdata1_d   = rdata1_q;
      REQ0_READY = 1'b0;
      REQ1_READY = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // A busy sram_interface (left over from an aborted cycle) blocks grants.
            if (any_valid && !SRAM_STATUS) begin
               win_d   = grant;
               state_d = ST_ISSUE;
               if (grant) begin
                  REQ1_READY = 1'b1;
                  wr_d       = REQ1_WRITE;
                  addr_d     = REQ1_ADDR;
                  wdata_d    = REQ1_WDATA;
               end else begin
                  REQ0_READY = 1'b1;
                  wr_d       = REQ0_WRITE;
                  addr_d     = REQ0_ADDR;
                  wdata_d    = REQ0_WDATA;
               end
            end
         end
         ST_ISSUE: begin
            // Leaving ISSUE drops SRAM_CMD, so the command is never seen again
            // once sram_interface returns idle.
            if (timeout_hit) begin
               state_d = ST_DONE;
            end else if (SRAM_STATUS) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (timeout_hit) begin
               state_d = ST_DONE;
            end else if (!SRAM_STATUS) begin
               state_d = ST_DONE;
               // Capture here so the data is visible in the same cycle as DONE.
               if (!wr_q) begin
                  if (win_q) begin
                     rdata1_d = SRAM_RDATA;
                  end else begin
                     rdata0_d = SRAM_RDATA;
                  end
               end
            end
         end
         ST_DONE: begin
            ptr_d   = ~win_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK_48MHZ or posedge RESET) begin
      if (RESET) begin
         state_q  <= ST_IDLE;
         ptr_q    <= 1'b0;
         win_q    <= 1'b0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         win_q    <= win_d;
         wr_q     <= wr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
      end
   end

   assign SRAM_CMD   = (state_q == ST_ISSUE) ? op_to_cmd(wr_q) : CMD_IDLE;
   assign SRAM_ADDR  = addr_q[WORD_MSB:0];
   assign SRAM_CS    = addr_q[CS_BIT];
   assign SRAM_WDATA = wdata_q;
   assign REQ0_DONE  = (state_q == ST_DONE) && !win_q;
   assign REQ1_DONE  = (state_q == ST_DONE) && win_q;
   assign REQ0_RDATA = rdata0_q;
   assign REQ1_RDATA = rdata1_q;

endmodule
